// File: rtl/math_cabs_32_pipe.sv
// rtl/math_cabs_32_pipe.sv - fully pipelined unscaled CORDIC complex magnitude |a + jb|
module math_cabs_32_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int ITERATIONS = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] dina,
   input  logic [DATA_WIDTH-1:0] dinb,
   output logic [DATA_WIDTH+1:0] dout
);

   // Input register + one register per micro-rotation + output register.
   localparam int LATENCY = ITERATIONS + 2;
   // Three guard bits: one for |-2^(N-1)|, two for CORDIC gain growth up to sqrt(2)*K.
   localparam int W       = DATA_WIDTH + 3;
   localparam int NSTAGE  = LATENCY - 1;

   // x/y pipeline: index 0 is the input stage, index i+1 holds the result of rotation i.
   logic signed [W-1:0]          x_q [0:NSTAGE-1] = '{default: '0};
   logic signed [W-1:0]          y_q [0:NSTAGE-1] = '{default: '0};
   logic signed [W-1:0]          x_d [0:NSTAGE-1];
   logic signed [W-1:0]          y_d [0:NSTAGE-1];
   logic        [DATA_WIDTH+1:0] dout_q = '0;
   logic        [DATA_WIDTH+1:0] dout_d;

   logic signed [W-1:0]          a_ext;
   logic signed [W-1:0]          b_ext;

   // Sign-extend both components into the wide datapath.
   always_comb begin
      a_ext = {{(W-DATA_WIDTH){dina[DATA_WIDTH-1]}}, dina};
      b_ext = {{(W-DATA_WIDTH){dinb[DATA_WIDTH-1]}}, dinb};
   end

   // Next-state for every stage: fold a into the right half-plane, then
   // rotate towards the x axis, choosing direction from the sign of y.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      x_d[0] = a_ext[W-1] ? -a_ext : a_ext;
      y_d[0] = b_ext;
      for (int i = 0; i < ITERATIONS; i++) begin
         if (!y_q[i][W-1]) begin
            x_d[i+1] = x_q[i] + (y_q[i] >>> i);
            y_d[i+1] = y_q[i] - (x_q[i] >>> i);
         end else begin
            x_d[i+1] = x_q[i] - (y_q[i] >>> i);
            y_d[i+1] = y_q[i] + (x_q[i] >>> i);
         end
      end
   end

   // Final x is non-negative and below 2^(DATA_WIDTH+1), so the low bits are the magnitude.
   always_comb begin
      dout_d = x_q[NSTAGE-1][DATA_WIDTH+1:0];
   end

   // Pipeline registers; reset flushes every stage so in-flight samples are lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NSTAGE; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
         dout_q <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: tb/tb_math_cabs_32_pipe.sv
// tb/tb_math_cabs_32_pipe.sv - scoreboard bench for math_cabs_32_pipe
module tb_math_cabs_32_pipe;

   localparam int DW  = 32;
   localparam int IT  = 12;
   localparam int LAT = IT + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] dina;
   logic [DW-1:0] dinb;
   logic [DW+1:0] dout;

   always #5 clk = ~clk;

   math_cabs_32_pipe #(.DATA_WIDTH(DW), .ITERATIONS(IT)) dut (
      .clk  (clk),
      .rst  (rst),
      .dina (dina),
      .dinb (dinb),
      .dout (dout)
   );

   typedef struct {
      bit            exact;
      logic [DW+1:0] val;
      real           mag;
      real           tol;
      int            id;
      string         tag;
   } exp_t;

   exp_t          sb[$];
   int            pass_cnt  = 0;
   int            total_cnt = 0;
   real           k_gain;
   real           rel_err;
   logic [DW+1:0] sym_pp = '0;
   logic [DW+1:0] sym_np = '0;

   function automatic real ref_mag(input logic [DW-1:0] a, input logic [DW-1:0] b);
      real ra;
      real rb;
      ra = real'($signed(a));
      rb = real'($signed(b));
      return k_gain * $sqrt(ra * ra + rb * rb);
   endfunction

   // Compare the oldest outstanding expectation with the current dout.
   task automatic pop_check();
      exp_t e;
      real  err;
      e = sb.pop_front();
      total_cnt++;
      if (e.id == 1) sym_pp = dout;
      if (e.id == 2) sym_np = dout;
      if (e.exact) begin
         assert (dout === e.val) pass_cnt++;
         else $error("FAIL %s observed=%0d expected=%0d", e.tag, dout, e.val);
      end else begin
         err = real'(dout) - e.mag;
         if (err < 0.0) err = -err;
         assert ((err <= e.tol) === 1'b1) pass_cnt++;
         else $error("FAIL %s observed=%0d expected=%0.1f tol=%0.1f", e.tag, dout, e.mag, e.tol);
      end
   endtask

   // One clock: drive inputs, record expectation, advance, sample on the falling edge.
   task automatic step(input logic r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input int id, input string tag);
      exp_t e;
      rst  = r;
      dina = a;
      dinb = b;
      if (r) begin
         foreach (sb[i]) begin
            sb[i].exact = 1'b1;
            sb[i].val   = '0;
         end
      end
      e.exact = r || (a == '0 && b == '0);
      e.val   = '0;
      e.mag   = ref_mag(a, b);
      // Truncation budget plus the residual-angle shortfall K*r*(1-cos(atan(2^-(IT-1)))).
      e.tol   = real'(2 * IT + 4) + e.mag * rel_err;
      e.id    = id;
      e.tag   = tag;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (r) begin
         total_cnt++;
         assert (dout === '0) pass_cnt++;
         else $error("FAIL rst_dout observed=%0d expected=0", dout);
      end
      if (sb.size() >= LAT) pop_check();
   endtask

   initial begin
      k_gain = 1.0;
      for (int i = 0; i < IT; i++) k_gain = k_gain * $sqrt(1.0 + 1.0 / real'(64'd1 << (2 * i)));
      rel_err = 1.0 - $cos($atan(1.0 / real'(64'd1 << (IT - 1))));

      rst  = 1'b0;
      dina = '0;
      dinb = '0;
      #1;
      total_cnt++;
      assert (dout === '0) pass_cnt++;
      else $error("FAIL powerup observed=%0d expected=0", dout);

      // Reset with full-scale inputs, then release with zero inputs.
      for (int i = 0; i < 3; i++) step(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, "rst_hold");
      for (int i = 0; i < 13; i++) step(1'b0, '0, '0, 0, "post_rst_zero");

      // Single impulse surrounded by zeros.
      step(1'b0, 32'd1000, '0, 0, "impulse");
      for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 0, "impulse_zero");

      // Back-to-back stream of distinct samples.
      for (int k = 0; k < 16; k++) begin
         int sa;
         int sb_v;
         sa   = k * 250000 - 1800000;
         sb_v = 3000000 - k * k * 9000;
         step(1'b0, 32'(sa), 32'(sb_v), 0, "stream");
      end

      // Quadrant symmetry.
      step(1'b0, 32'(3000),  32'(4000),  1, "sym_pp");
      step(1'b0, 32'(-3000), 32'(4000),  2, "sym_np");
      step(1'b0, 32'(3000),  32'(-4000), 0, "sym_pn");
      step(1'b0, 32'(-3000), 32'(-4000), 0, "sym_nn");

      // Extremes.
      step(1'b0, 32'h8000_0000, 32'h8000_0000, 0, "ext_min_min");
      step(1'b0, 32'h7FFF_FFFF, 32'h0000_0000, 0, "ext_max_0");
      step(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 0, "ext_min_max");

      // Random pairs.
      for (int n = 0; n < 10000; n++) step(1'b0, $urandom(), $urandom(), 0, "random");

      // Reset pulse with eight samples in flight, then fresh samples.
      for (int k = 1; k <= 8; k++) step(1'b0, 32'(k * 50000), 32'(-k * 30000), 0, "inflight");
      step(1'b1, 32'h1234_5678, 32'h0765_4321, 0, "rst_pulse");
      for (int k = 1; k <= 8; k++) step(1'b0, 32'(k * 70000), 32'(k * 11000), 0, "post_rst");
      for (int i = 0; i < LAT; i++) step(1'b0, '0, '0, 0, "flush");

      total_cnt++;
      assert (sym_pp === sym_np) pass_cnt++;
      else $error("FAIL sym_bitexact observed=%0d expected=%0d", sym_np, sym_pp);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
